// File: rtl/thor2022_bus_arbiter.sv
// Two-master round-robin Wishbone arbiter for the Thor2022 128-bit external bus.
// Optional stall watchdog enabled by defining THOR2022_BUS_ARB_TIMEOUT_EN.
module thor2022_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [2:0]        m0_cti_i,
    input  logic [1:0]        m0_bte_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DW-1:0]     m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [2:0]        m1_cti_i,
    input  logic [1:0]        m1_bte_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DW-1:0]     m1_dat_o,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [DW/8-1:0]   sel_o,
    output logic [AW-1:0]     adr_o,
    output logic [DW-1:0]     dat_o,
    output logic [2:0]        cti_o,
    output logic [1:0]        bte_o,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [DW-1:0]     dat_i,
    output logic [1:0]        gnt_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       r_last;
    logic       w_last_nxt;
    logic       w_own0;
    logic       w_own1;
    logic       w_err;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);
    assign gnt_o  = {w_own1, w_own0};

    // Owner returns to IDLE when it drops cyc, which guarantees a dead cycle between owners.
    always_comb begin
        w_next     = r_state;
        w_last_nxt = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next     = r_last ? OWN0 : OWN1;
                    w_last_nxt = ~r_last;
                end else if (m0_cyc_i) begin
                    w_next     = OWN0;
                    w_last_nxt = 1'b0;
                end else if (m1_cyc_i) begin
                    w_next     = OWN1;
                    w_last_nxt = 1'b1;
                end
            end
            OWN0:    if (!m0_cyc_i) w_next = IDLE;
            OWN1:    if (!m1_cyc_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_nxt;
        end
    end

    assign cyc_o = (w_own0 & m0_cyc_i) | (w_own1 & m1_cyc_i);
    assign stb_o = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
    assign we_o  = (w_own0 & m0_we_i)  | (w_own1 & m1_we_i);
    assign sel_o = ({(DW/8){w_own0}} & m0_sel_i) | ({(DW/8){w_own1}} & m1_sel_i);
    assign adr_o = ({AW{w_own0}} & m0_adr_i) | ({AW{w_own1}} & m1_adr_i);
    assign dat_o = ({DW{w_own0}} & m0_dat_i) | ({DW{w_own1}} & m1_dat_i);
    assign cti_o = ({3{w_own0}} & m0_cti_i) | ({3{w_own1}} & m1_cti_i);
    assign bte_o = ({2{w_own0}} & m0_bte_i) | ({2{w_own1}} & m1_bte_i);

`ifdef THOR2022_BUS_ARB_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_tmo;

    // A real ack/err in the timeout cycle wins: the forced error is only armed while still stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= 8'd0;
            r_tmo  <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            if (ack_i || err_i || !cyc_o) begin
                r_wdog <= 8'd0;
            end else if (stb_o) begin
                if (r_wdog == 8'(TIMEOUT)) begin
                    r_wdog <= 8'd0;
                    r_tmo  <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 8'd1;
                end
            end
        end
    end

    assign w_err = err_i | r_tmo;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_err            = err_i;
`endif

    assign m0_ack_o = w_own0 & ack_i;
    assign m1_ack_o = w_own1 & ack_i;
    assign m0_err_o = w_own0 & w_err;
    assign m1_err_o = w_own1 & w_err;
    assign m0_dat_o = {DW{w_own0}} & dat_i;
    assign m1_dat_o = {DW{w_own1}} & dat_i;
endmodule

// File: tb/tb_thor2022_bus_arbiter.sv
// Scoreboarded bench for thor2022_bus_arbiter: responses are checked by a negedge monitor,
// grant/mux timing by directed checks in the stimulus thread.
module tb_thor2022_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [2:0]    m0_cti_i;
    logic [1:0]    m0_bte_i;
    logic          m0_ack_o, m0_err_o;
    logic [DW-1:0] m0_dat_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [2:0]    m1_cti_i;
    logic [1:0]    m1_bte_i;
    logic          m1_ack_o, m1_err_o;
    logic [DW-1:0] m1_dat_o;
    logic          cyc_o, stb_o, we_o;
    logic [SW-1:0] sel_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [2:0]    cti_o;
    logic [1:0]    bte_o;
    logic          ack_i, err_i;
    logic [DW-1:0] dat_i;
    logic [1:0]    gnt_o;

    thor2022_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
        .dat_o(dat_o), .cti_o(cti_o), .bte_o(bte_o),
        .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i), .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          m0a;
        logic          m0e;
        logic          m1a;
        logic          m1e;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } resp_t;

    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic resp_t mk(input logic [3:0] fl, input logic [DW-1:0] d0,
                                 input logic [DW-1:0] d1);
        resp_t r;
        r.m0a = fl[3];
        r.m0e = fl[2];
        r.m1a = fl[1];
        r.m1e = fl[0];
        r.d0  = d0;
        r.d1  = d1;
        return r;
    endfunction

    // Response monitor: every ack/err the DUT presents must match the next queued expectation.
    always @(negedge clk_i) begin
        resp_t a;
        resp_t e;
        if (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
            a = mk({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, m0_dat_o, m1_dat_o);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected act=%h", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL resp act=%h exp=%h", a, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic release_all();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = '0; m0_adr_i = '0;
        m0_dat_i = '0; m0_cti_i = '0; m0_bte_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = '0; m1_adr_i = '0;
        m1_dat_i = '0; m1_cti_i = '0; m1_bte_i = '0;
        ack_i = 0; err_i = 0; dat_i = '0;
        nxt();
        nxt();
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL tb_time_limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int w;
        int first;
        int errs;
        logic [DW-1:0] d;

        release_all();
        neg();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_cyc", cyc_o, 0);
        nxt();
        rst_ni = 1;

        // T1: reset mid-OWN1 with cyc_o high
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_1000;
        nxt(); neg();
        chk("t1_own1_gnt", gnt_o, 2'b10);
        chk("t1_own1_cyc", cyc_o, 1);
        #1; rst_ni = 0; ack_i = 1; #1;
        chk("t1_rst_gnt", gnt_o, 0);
        chk("t1_rst_cyc", cyc_o, 0);
        chk("t1_rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
        nxt();
        ack_i = 0; rst_ni = 1; m0_cyc_i = 1; m0_stb_i = 1;
        nxt(); neg();
        chk("t1_first_win", gnt_o, 2'b01);
        release_all();

        // T2: single master write, ack in the same cycle m1 drops cyc
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'hFF96_0010;
        m1_sel_i = 16'h00F0; m1_dat_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        neg();
        chk("t2_idle_gnt", gnt_o, 0);
        chk("t2_idle_adr", adr_o, 0);
        nxt(); neg();
        chk("t2_gnt", gnt_o, 2'b10);
        chk("t2_adr", adr_o, 32'hFF96_0010);
        chk("t2_sel", sel_o, 16'h00F0);
        chk("t2_we", we_o, 1);
        chk("t2_dat", dat_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        nxt();
        nxt();
        ack_i = 1; dat_i = 128'h5; m1_cyc_i = 0; m1_stb_i = 0;
        exp_q.push_back(mk(4'b0010, '0, 128'h5));
        neg();
        chk("t2_gnt_hold", gnt_o, 2'b10);
        nxt();
        ack_i = 0; dat_i = '0;
        neg();
        chk("t2_release_gnt", gnt_o, 0);
        chk("t2_release_cyc", cyc_o, 0);
        release_all();

        // T3: round-robin with one dead cycle between owners
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'hA000_0000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'hB000_0000;
        for (int i = 0; i < 8; i++) begin
            w = i % 2;
            nxt();
            d = 128'(i + 32'h100);
            ack_i = 1; dat_i = d;
            if (w == 0) begin
                m0_cyc_i = 0; m0_stb_i = 0;
                exp_q.push_back(mk(4'b1000, d, '0));
            end else begin
                m1_cyc_i = 0; m1_stb_i = 0;
                exp_q.push_back(mk(4'b0010, '0, d));
            end
            neg();
            chk("t3_owner", gnt_o, (w == 0) ? 2'b01 : 2'b10);
            nxt();
            ack_i = 0; dat_i = '0;
            if (w == 0) begin m0_cyc_i = 1; m0_stb_i = 1; end
            else begin m1_cyc_i = 1; m1_stb_i = 1; end
            neg();
            chk("t3_dead_gnt", gnt_o, 0);
            chk("t3_dead_adr", adr_o, 0);
        end
        release_all();

        // T4: locked 4-beat burst from m0 while m1 waits
        m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = 3'b010; m0_adr_i = 32'h0000_2000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h0000_3000;
        nxt();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) nxt();
            d = 128'(k + 32'h40);
            ack_i = 1; dat_i = d;
            m0_cti_i = (k == 3) ? 3'b111 : 3'b010;
            m0_adr_i = 32'h0000_2000 + 32'(k * 16);
            exp_q.push_back(mk(4'b1000, d, '0));
            neg();
            chk("t4_burst_gnt", gnt_o, 2'b01);
            chk("t4_cti", cti_o, (k == 3) ? 3'b111 : 3'b010);
            chk("t4_adr", adr_o, 32'h0000_2000 + 32'(k * 16));
        end
        nxt();
        ack_i = 0; dat_i = '0; m0_stb_i = 0; m0_cti_i = '0;
        neg();
        chk("t4_lock_hold1", gnt_o, 2'b01);
        nxt(); neg();
        chk("t4_lock_hold2", gnt_o, 2'b01);
        nxt();
        m0_cyc_i = 0;
        neg();
        chk("t4_drop_cycle", gnt_o, 2'b01);
        nxt(); neg();
        chk("t4_dead", gnt_o, 0);
        nxt(); neg();
        chk("t4_m1_gnt", gnt_o, 2'b10);
        release_all();

        // T6: read data steering, plus simultaneous ack and err
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_4000;
        nxt();
        d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        ack_i = 1; dat_i = d;
        exp_q.push_back(mk(4'b1000, d, '0));
        neg();
        chk("t6_m0_dat", m0_dat_o, d);
        chk("t6_m1_dat", m1_dat_o, 0);
        nxt();
        ack_i = 1; err_i = 1; dat_i = '0;
        exp_q.push_back(mk(4'b1100, '0, '0));
        nxt();
        ack_i = 0; err_i = 0;
        release_all();

        // T5: slave never acks
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_5000;
        nxt();
        first = -1;
        errs  = 0;
`ifdef THOR2022_BUS_ARB_TIMEOUT_EN
        exp_q.push_back(mk(4'b0100, '0, '0));
        for (int n = 0; n < 30; n++) begin
            neg();
            if (m0_err_o) begin
                if (first < 0) first = n;
                errs++;
            end
            nxt();
        end
        chk("t5_err_cycle", 128'(first), 128'(17));
        chk("t5_err_len", 128'(errs), 128'(1));
`else
        for (int n = 0; n < 1000; n++) begin
            neg();
            if (m0_err_o) errs++;
            nxt();
        end
        chk("t5_no_err", 128'(errs), 128'(0));
        chk("t5_still_owned", gnt_o, 2'b01);
`endif
        release_all();

        chk("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
